// File: rtl/tomasulo_pkg.sv
// Shared CDB types: slot-reservation vector, result tag/word and the broadcast record.
package tomasulo_pkg;

   localparam int TAG_W     = 6;
   localparam int W_W       = 32;
   localparam int DEF_SCH_N = 8;
   localparam int LAT_W     = 4;

   typedef logic [DEF_SCH_N-1:0] sch_t;
   typedef logic [TAG_W-1:0]     tag_t;
   typedef logic [W_W-1:0]       word_t;

   typedef struct packed {
      logic  vld;
      tag_t  tag;
      word_t wdata;
   } cdb_t;

endpackage

// File: rtl/tomasulo_rr_arb.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
module tomasulo_rr_arb #(
   parameter  int N  = 3,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   int   idx;
   logic found;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tomasulo_cdb_arb.sv
// CDB owner: round-robin grant, slot-reservation shift vector, registered result broadcast.
// Define TOMASULO_CDB_CHECK_EN to build the sticky protocol checker behind cdb_err_r.
module tomasulo_cdb_arb
   import tomasulo_pkg::*;
#(
   parameter int                    RS_N  = 3,
   parameter int                    SCH_N = DEF_SCH_N,
   parameter logic [RS_N*LAT_W-1:0] LAT   = {4'd5, 4'd3, 4'd2}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [RS_N-1:0]       cdb_req,
   output logic [RS_N-1:0]       cdb_gnt,
   output logic [SCH_N-1:0]      sch_r,
   input  logic [RS_N-1:0]       exe_vld,
   input  logic [RS_N*TAG_W-1:0] exe_tag,
   input  logic [RS_N*W_W-1:0]   exe_wdata,
   output cdb_t                  cdb_r,
   output logic                  cdb_err_r
);

   localparam int PTR_W = (RS_N > 1) ? $clog2(RS_N) : 1;

   logic [PTR_W-1:0] rr_r, rr_nxt;
   logic [RS_N-1:0]  elig, gnt_raw;
   logic [SCH_N-1:0] add_v [RS_N];
   logic [SCH_N-1:0] sch_add, sch_w;
   logic             cap_vld;
   tag_t             cap_tag;
   word_t            cap_wdata;

   // A grant to i lands its result L_i cycles out, i.e. at index L_i-1 of next cycle's vector.
   for (genvar g = 0; g < RS_N; g++) begin : g_rs
      localparam int L = int'(LAT[g*LAT_W +: LAT_W]);
      assign elig[g]  = cdb_req[g] & ~sch_r[L];
      assign add_v[g] = cdb_gnt[g] ? (SCH_N'(1) << (L - 1)) : '0;
   end

   tomasulo_rr_arb #(.N(RS_N)) u_rr_arb (
      .req (elig),
      .ptr (rr_r),
      .gnt (gnt_raw)
   );

   assign cdb_gnt = rst ? '0 : gnt_raw;

   always_comb begin
      sch_add = '0;
      rr_nxt  = rr_r;
      for (int i = 0; i < RS_N; i++) begin
         sch_add = sch_add | add_v[i];
         if (cdb_gnt[i]) rr_nxt = (i == RS_N - 1) ? '0 : PTR_W'(i + 1);
      end
      sch_w = (sch_r >> 1) | sch_add;
   end

   // Lowest-index result wins; tag/wdata hold their last broadcast otherwise.
   always_comb begin
      cap_vld   = |exe_vld;
      cap_tag   = cdb_r.tag;
      cap_wdata = cdb_r.wdata;
      for (int i = RS_N - 1; i >= 0; i--) begin
         if (exe_vld[i]) begin
            cap_tag   = exe_tag[i*TAG_W +: TAG_W];
            cap_wdata = exe_wdata[i*W_W +: W_W];
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sch_r <= '0;
         rr_r  <= '0;
         cdb_r <= '0;
      end else begin
         sch_r       <= sch_w;
         rr_r        <= rr_nxt;
         cdb_r.vld   <= cap_vld;
         cdb_r.tag   <= cap_tag;
         cdb_r.wdata <= cap_wdata;
      end
   end

`ifdef TOMASULO_CDB_CHECK_EN
   logic multi_vld, slot_mismatch, bad_gnt;

   assign multi_vld     = (exe_vld & (exe_vld - RS_N'(1))) != '0;
   assign slot_mismatch = (|exe_vld) != sch_r[0];
   assign bad_gnt       = |(cdb_gnt & ~elig);

   always_ff @(posedge clk) begin
      if (rst)                                       cdb_err_r <= 1'b0;
      else if (multi_vld || slot_mismatch || bad_gnt) cdb_err_r <= 1'b1;
   end

   always @(posedge clk) begin
      if (!rst) begin
         assert (!multi_vld)     else $error("cdb: more than one exe_vld in a cycle");
         assert (!slot_mismatch) else $error("cdb: exe_vld disagrees with sch_r[0]");
         assert (!bad_gnt)       else $error("cdb: grant to an ineligible requester");
      end
   end
`else
   assign cdb_err_r = 1'b0;
`endif

endmodule

// File: tb/tb_tomasulo_cdb_arb.sv
// Cycle model of the CDB arbiter with a broadcast scoreboard; directed scenarios then random traffic.
module tb_tomasulo_cdb_arb;
   import tomasulo_pkg::*;

   localparam int RS_N  = 3;
   localparam int SCH_N = 8;
   localparam int LATS [RS_N] = '{2, 3, 5};

   logic                  clk;
   logic                  rst;
   logic [RS_N-1:0]       cdb_req;
   logic [RS_N-1:0]       cdb_gnt;
   logic [SCH_N-1:0]      sch_r;
   logic [RS_N-1:0]       exe_vld;
   logic [RS_N*TAG_W-1:0] exe_tag;
   logic [RS_N*W_W-1:0]   exe_wdata;
   cdb_t                  cdb_r;
   logic                  cdb_err_r;

   tomasulo_cdb_arb #(
      .RS_N  (RS_N),
      .SCH_N (SCH_N),
      .LAT   ({4'd5, 4'd3, 4'd2})
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cdb_req   (cdb_req),
      .cdb_gnt   (cdb_gnt),
      .sch_r     (sch_r),
      .exe_vld   (exe_vld),
      .exe_tag   (exe_tag),
      .exe_wdata (exe_wdata),
      .cdb_r     (cdb_r),
      .cdb_err_r (cdb_err_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int    due;
      int    unit;
      tag_t  tag;
      word_t wdata;
   } pend_t;

   typedef struct {
      int    due;
      tag_t  tag;
      word_t wdata;
   } exp_t;

   pend_t            pend_q [$];
   exp_t             exp_q  [$];
   int               cyc;
   logic [SCH_N-1:0] m_sch;
   int               m_rr;
   bit               m_err;
   tag_t             m_tag;
   word_t            m_wdata;
   int               n_checks;
   int               n_fail;
   bit               ovr_en;
   tag_t             ovr_tag;
   word_t            ovr_wdata;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", name, cyc, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, compare registered state at negedge+1, advance the model.
   task automatic step(input logic [RS_N-1:0] raw, input bit gate, input bit do_rst,
                       input logic [RS_N-1:0] inj);
      logic [RS_N-1:0]       req, vld, elig, eg;
      logic [RS_N*TAG_W-1:0] tg;
      logic [RS_N*W_W-1:0]   wd;
      logic [SCH_N-1:0]      nsch;
      int                    g, idx, lo;
      bit                    cond;
      exp_t                  e;

      @(negedge clk);
      req = raw;
      for (int i = 0; i < RS_N; i++)
         if (gate && m_sch[LATS[i]]) req[i] = 1'b0;

      vld = inj;
      tg  = '0;
      wd  = '0;
      for (int i = 0; i < RS_N; i++) begin
         if (inj[i]) begin
            tg[i*TAG_W +: TAG_W] = tag_t'($urandom);
            wd[i*W_W +: W_W]     = $urandom;
         end
      end
      for (int j = pend_q.size() - 1; j >= 0; j--) begin
         if (pend_q[j].due == cyc) begin
            vld[pend_q[j].unit]                   = 1'b1;
            tg[pend_q[j].unit*TAG_W +: TAG_W]     = pend_q[j].tag;
            wd[pend_q[j].unit*W_W +: W_W]         = pend_q[j].wdata;
            pend_q.delete(j);
         end
      end

      rst       = do_rst;
      cdb_req   = req;
      exe_vld   = vld;
      exe_tag   = tg;
      exe_wdata = wd;

      g = -1;
      for (int i = 0; i < RS_N; i++) elig[i] = req[i] & ~m_sch[LATS[i]];
      if (!do_rst) begin
         for (int k = 0; k < RS_N; k++) begin
            idx = (m_rr + k) % RS_N;
            if (g < 0 && elig[idx]) g = idx;
         end
      end
      eg = (g >= 0) ? (RS_N'(1) << g) : '0;

      #1;
      check("gnt", 64'(cdb_gnt), 64'(eg));
      check("sch", 64'(sch_r), 64'(m_sch));
      check("err", 64'(cdb_err_r), 64'(m_err));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         check("cdb_vld", 64'(cdb_r.vld), 64'(1));
         check("cdb_tag", 64'(cdb_r.tag), 64'(e.tag));
         check("cdb_wdata", 64'(cdb_r.wdata), 64'(e.wdata));
         m_tag   = e.tag;
         m_wdata = e.wdata;
      end else begin
         check("cdb_idle_vld", 64'(cdb_r.vld), 64'(0));
         check("cdb_hold_tag", 64'(cdb_r.tag), 64'(m_tag));
         check("cdb_hold_wdata", 64'(cdb_r.wdata), 64'(m_wdata));
      end

      if (do_rst) begin
         m_sch   = '0;
         m_rr    = 0;
         m_err   = 1'b0;
         m_tag   = '0;
         m_wdata = '0;
      end else begin
         cond = ($countones(vld) > 1) || ((|vld) != m_sch[0]);
`ifdef TOMASULO_CDB_CHECK_EN
         m_err = m_err | cond;
`endif
         nsch = m_sch >> 1;
         if (g >= 0) begin
            nsch[LATS[g] - 1] = 1'b1;
            m_rr = (g + 1) % RS_N;
            pend_q.push_back('{due: cyc + LATS[g], unit: g,
                               tag: ovr_en ? ovr_tag : tag_t'($urandom),
                               wdata: ovr_en ? ovr_wdata : word_t'($urandom)});
            ovr_en = 1'b0;
         end
         m_sch = nsch;
         if (|vld) begin
            lo = -1;
            for (int i = RS_N - 1; i >= 0; i--) if (vld[i]) lo = i;
            exp_q.push_back('{due: cyc + 1, tag: tg[lo*TAG_W +: TAG_W],
                              wdata: wd[lo*W_W +: W_W]});
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0, '0);
   endtask

   initial begin
      rst = 1'b1; cdb_req = '0; exe_vld = '0; exe_tag = '0; exe_wdata = '0;
      cyc = 0; m_sch = '0; m_rr = 0; m_err = 1'b0; m_tag = '0; m_wdata = '0;
      n_checks = 0; n_fail = 0; ovr_en = 1'b0; ovr_tag = '0; ovr_wdata = '0;

      // Reset: grant must stay low even with requests present.
      step(3'b111, 1'b0, 1'b1, '0);
      step(3'b111, 1'b0, 1'b1, '0);
      idle(2);

      // Single request with a fixed result.
      ovr_en = 1'b1; ovr_tag = 6'd5; ovr_wdata = 32'hAB;
      step(3'b001, 1'b1, 1'b0, '0);
      idle(4);

      // Round-robin fairness with all stations requesting.
      for (int i = 0; i < 6; i++) step(3'b111, 1'b1, 1'b0, '0);
      idle(8);

      // Collision block: ungated request 0 right after a grant to 1.
      step(3'b010, 1'b1, 1'b0, '0);
      step(3'b001, 1'b0, 1'b0, '0);
      step(3'b001, 1'b1, 1'b0, '0);
      idle(6);

      // Back-to-back grants with different latencies.
      step(3'b100, 1'b1, 1'b0, '0);
      step(3'b001, 1'b1, 1'b0, '0);
      idle(7);

      // Reset mid-flight; the in-flight result still arrives afterwards.
      step(3'b100, 1'b1, 1'b0, '0);
      idle(1);
      step('0, 1'b1, 1'b1, '0);
      step(3'b001, 1'b1, 1'b0, '0);
      idle(7);

      // Random traffic, mostly station-gated, sometimes raw.
      for (int i = 0; i < 60; i++)
         step(RS_N'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, 1'b0, '0);
      idle(8);

      // Protocol violation: two results with no reservation, then clear by reset.
      step('0, 1'b1, 1'b1, '0);
      step('0, 1'b1, 1'b0, 3'b011);
      idle(3);
      step('0, 1'b1, 1'b1, '0);
      idle(2);

      check("drain_exp", 64'(exp_q.size()), 64'(0));
      check("drain_pend", 64'(pend_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tomasulo_cdb_arb.md
Name: tomasulo_cdb_arb

Overview:
Owns the Common Data Bus (CDB). Reservation stations raise cdb_req; this block round-robin arbitrates them and returns a same-cycle cdb_gnt. It maintains the CDB slot-reservation vector sch_r, which every station reads to suppress requests that would collide. When execution results arrive, it registers them and broadcasts the single cdb_r word that all stations snoop.

Parameters:
RS_N, 3, number of reservation stations / execution units (>=2).
SCH_N, 8, depth of the slot-reservation vector sch_r.
LAT, {4'd5,4'd3,4'd2}, packed per-requester execution latency; field i is L_i; 2 <= L_i <= SCH_N-1.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
cdb_req  in  RS_N  per-station request, already gated by ~sch_r[L_i].
cdb_gnt  out  RS_N  one-hot-or-zero grant, combinational in the request cycle.
sch_r  out  SCH_N  slot-reservation vector (tomasulo_pkg::sch_t), registered.
exe_vld  in  RS_N  execution-unit result valid.
exe_tag  in  RS_N*TAG_W  per-unit result tag.
exe_wdata  in  RS_N*W_W  per-unit result data.
cdb_r  out  cdb_t  registered broadcast {vld, tag, wdata}.
cdb_err_r  out  1  sticky protocol error flag.

Behaviour:
- Reset values: sch_r=0, cdb_r.vld=0, cdb_r tag/wdata=0, cdb_err_r=0, rr_r=0; cdb_gnt=0 in any cycle where rst=1.
- Eligibility: requester i is eligible when cdb_req[i] & ~sch_r[L_i]. The sch_r check is defensive and duplicates the station's own gating.
- Arbitration: scan eligible requesters starting at rr_r, wrapping modulo RS_N; the first hit wins. At most one grant per cycle.
- Pointer update: on a grant to i, rr_r <= (i+1) mod RS_N. With no grant, rr_r holds.
- Timeline for a grant to i at cycle t: the station issues at t+1, exe_vld[i] arrives at t+L_i, and cdb_r.vld is high at t+L_i+1 carrying exe_tag[i]/exe_wdata[i].
- Reservation semantics: sch_r[k]=1 at cycle c means an exe result is due at cycle c+k (k=0 means this cycle).
- Reservation next-state: sch_w = (sch_r >> 1) | (gnt_any ? 1<<(L_gnt-1) : 0). Bits shifted past 0 are dropped. sch_r updates every cycle.
- Broadcast capture: cdb_r <= {1, tag, wdata} of the lowest-index asserted exe_vld; otherwise cdb_r.vld <= 0. tag and wdata hold when no result arrives.
- Simultaneous events:
  - A new grant whose bit lands on an already-set bit cannot occur, because it is blocked by eligibility.
  - A grant and a shift in the same cycle are ORed.
  - Any cdb_req with all requesters blocked gives gnt=0 and leaves the pointer unchanged.
- Reset mid-operation: all reservations are dropped. Results arriving after reset are still broadcast, but are flagged as errors when the check feature is enabled.
- Throughput: one broadcast per cycle maximum; back-to-back grants are allowed when their slots differ.

Optional Feature:
Macro: TOMASULO_CDB_CHECK_EN.
- Enabled: cdb_err_r sets (sticky until rst) when any of the following occurs:
  - popcount(exe_vld) > 1;
  - |exe_vld != sch_r[0];
  - cdb_gnt is non-zero for a requester that is not eligible.
- Enabled: the same conditions are also reported as simulation assertions.
- Disabled: the check logic is absent and cdb_err_r is tied to 0.

Decomposition:
- tomasulo_pkg holds: sch_t (logic [SCH_N-1:0]), cdb_t {vld, tag_t tag, word_t wdata}, TAG_W, W_W, and the default SCH_N.
- One sub-module: tomasulo_rr_arb (parameter N). Inputs are req and ptr; output is a one-hot gnt. It is purely combinational; the pointer flop stays in the parent.

Test Plan:
1. Single request: cdb_req=3'b001 at t=10, exe_vld[0] at t=12 with tag=5, wdata=0xAB.
   - cdb_gnt=001 at 10.
   - sch_r=0000_0010 at 11 and 0000_0001 at 12.
   - cdb_r={1,5,0xAB} at 13; cdb_r.vld=0 at 14.
2. Round-robin fairness: cdb_req=3'b111 held for 6 cycles, with sch_r kept clear by suppressing conflicts.
   - Grant sequence is 001, 010, 100, 001, ...
   - rr_r wraps from 2 to 0.
3. Collision block: grant to requester 1 (L=3) at t=20, then cdb_req=3'b001 (L=2) at t=21.
   - sch_r[2]=1 at 21, so there is no grant at 21.
   - Requester 0 is granted at 22; its broadcasts occur at 24 and 25, not overlapping.
4. Back-to-back with differing latency: requester 2 (L=5) at t=30, requester 0 (L=2) at t=31.
   - Both are granted.
   - Broadcasts occur at 34 (requester 0) and 36 (requester 2).
5. Reset mid-flight: grant to requester 2 at t=40, rst pulsed at t=42.
   - sch_r=0 and cdb_r.vld=0 at 43.
   - rr_r=0; the next request from requester 0 is granted immediately.
6. With TOMASULO_CDB_CHECK_EN: exe_vld=3'b011 injected with sch_r=0.
   - cdb_err_r=1 on the next cycle and remains set until rst.
